pipe_flush_ctrl: RTL and testbench

PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/flush_event_arb.sv | 47 ++++
 rtl/pipe_flush_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_flush_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : pipe_ctrl_pkg
// Brief   : Shared flush-cause codes and controller state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_JUMP = 2'b01,
        CAUSE_CALL = 2'b10,
        CAUSE_INT  = 2'b11
    } cause_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/flush_event_arb.sv
//------------------------------------------------------------------------------
// Module  : flush_event_arb
// Brief   : Fixed-priority pick of the flush event: interrupt > call > jump.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module flush_event_arb
    import pipe_ctrl_pkg::*;
#(
    parameter int JUMP_FLUSH_LEN = 1,
    parameter int CALL_FLUSH_LEN = 3,
    parameter int INT_FLUSH_LEN  = 4,
    parameter int CNT_W          = 4
) (
    input  logic             jump_i,
    input  logic             unc_jump_i,
    input  logic             call_i,
    input  logic             int_i,
    output logic             valid_o,
    output cause_t           cause_o,
    output logic [CNT_W-1:0] len_m1_o
);

    // Length is carried as N-1 so it lives in the same range as the counter.
    always_comb begin
        valid_o  = 1'b0;
        cause_o  = CAUSE_NONE;
        len_m1_o = '0;
        if (int_i) begin
            valid_o  = 1'b1;
            cause_o  = CAUSE_INT;
            len_m1_o = CNT_W'(INT_FLUSH_LEN - 1);
        end else if (call_i) begin
            valid_o  = 1'b1;
            cause_o  = CAUSE_CALL;
            len_m1_o = CNT_W'(CALL_FLUSH_LEN - 1);
        end else if (jump_i || unc_jump_i) begin
            valid_o  = 1'b1;
            cause_o  = CAUSE_JUMP;
            len_m1_o = CNT_W'(JUMP_FLUSH_LEN - 1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_flush_ctrl.sv
//------------------------------------------------------------------------------
// Module  : pipe_flush_ctrl
// Brief   : Front-end flush controller; counts flush cycles owed per event.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int JUMP_FLUSH_LEN = 1,
    parameter int CALL_FLUSH_LEN = 3,
    parameter int INT_FLUSH_LEN  = 4,
    parameter int MAX_FLUSH_LEN  = 15,
    localparam int CNT_W         = $clog2(MAX_FLUSH_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump,
    input  logic             unconditional_jump,
    input  logic             pc_to_stack,
    input  logic             interrupt,
    input  logic             stall,
    output logic             flush,
    output logic [1:0]       flush_cause,
    output logic [CNT_W-1:0] flush_remaining,
    output logic             busy
);

    if (MAX_FLUSH_LEN < 2 ||
        JUMP_FLUSH_LEN < 1 || JUMP_FLUSH_LEN > MAX_FLUSH_LEN ||
        CALL_FLUSH_LEN < 1 || CALL_FLUSH_LEN > MAX_FLUSH_LEN ||
        INT_FLUSH_LEN  < 1 || INT_FLUSH_LEN  > MAX_FLUSH_LEN) begin : g_len_check
        $error("pipe_flush_ctrl: flush length parameter out of range");
    end

    logic             ev_valid;
    cause_t           ev_cause;
    logic [CNT_W-1:0] ev_len_m1;

    flush_event_arb #(
        .JUMP_FLUSH_LEN (JUMP_FLUSH_LEN),
        .CALL_FLUSH_LEN (CALL_FLUSH_LEN),
        .INT_FLUSH_LEN  (INT_FLUSH_LEN),
        .CNT_W          (CNT_W)
    ) u_arb (
        .jump_i     (jump),
        .unc_jump_i (unconditional_jump),
        .call_i     (pc_to_stack),
        .int_i      (interrupt),
        .valid_o    (ev_valid),
        .cause_o    (ev_cause),
        .len_m1_o   (ev_len_m1)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cause_t           cause_q, cause_d;
    logic [CNT_W-1:0] base;

    // cnt counts flush cycles left including the current one while in FLUSH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        base    = stall ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (ev_valid) begin
                    cnt_d = ev_len_m1;
                    if (ev_len_m1 != '0) begin
                        state_d = ST_FLUSH;
                        cause_d = ev_cause;
                    end
                end
            end
            ST_FLUSH: begin
                if (ev_valid) begin
                    if (ev_len_m1 > base) begin
                        base = ev_len_m1;
                    end
                    cause_d = ev_cause;
                end
                if (base == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    cause_d = CAUSE_NONE;
                end else begin
                    cnt_d = base;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // IDLE outputs are Mealy so the first flush cycle coincides with the event.
    always_comb begin
        flush           = 1'b0;
        busy            = 1'b0;
        flush_remaining = '0;
        flush_cause     = CAUSE_NONE;
        if (!rst) begin
            if (state_q == ST_FLUSH) begin
                flush           = 1'b1;
                busy            = 1'b1;
                flush_remaining = cnt_q - 1'b1;
                flush_cause     = cause_q;
            end else if (ev_valid) begin
                flush           = 1'b1;
                flush_remaining = ev_len_m1;
                flush_cause     = ev_cause;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_flush_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_pipe_flush_ctrl
// Brief   : Directed cycle-by-cycle bench for pipe_flush_ctrl, default params.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       jump, unconditional_jump, pc_to_stack, interrupt, stall;
    logic       flush;
    logic [1:0] flush_cause;
    logic [3:0] flush_remaining;
    logic       busy;

    int total = 0;
    int bad   = 0;

    pipe_flush_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .jump               (jump),
        .unconditional_jump (unconditional_jump),
        .pc_to_stack        (pc_to_stack),
        .interrupt          (interrupt),
        .stall              (stall),
        .flush              (flush),
        .flush_cause        (flush_cause),
        .flush_remaining    (flush_remaining),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // in = {rst, interrupt, pc_to_stack, jump, unconditional_jump, stall}
    task automatic step(input string tag, input logic [5:0] in,
                        input logic ef, input logic [1:0] ec,
                        input logic [3:0] er, input logic eb);
        {rst, interrupt, pc_to_stack, jump, unconditional_jump, stall} = in;
        @(negedge clk);
        chk({tag, ".flush"}, {3'b0, flush}, {3'b0, ef});
        chk({tag, ".cause"}, {2'b0, flush_cause}, {2'b0, ec});
        chk({tag, ".rem"},   flush_remaining, er);
        chk({tag, ".busy"},  {3'b0, busy}, {3'b0, eb});
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] N   = 6'b000000;
    localparam logic [5:0] RST = 6'b100000;
    localparam logic [5:0] INT = 6'b010000;
    localparam logic [5:0] CAL = 6'b001000;
    localparam logic [5:0] JMP = 6'b000100;
    localparam logic [5:0] UJ  = 6'b000010;
    localparam logic [5:0] STL = 6'b000001;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        {rst, interrupt, pc_to_stack, jump, unconditional_jump, stall} = RST;
        @(posedge clk);
        #1;
        step("rst_ign",  RST | JMP | CAL, 1'b0, 2'b00, 4'd0, 1'b0);
        step("idle",     N,               1'b0, 2'b00, 4'd0, 1'b0);

        // single-cycle jump flushes, busy never rises
        step("jmp0",     JMP,             1'b1, 2'b01, 4'd0, 1'b0);
        step("jmp1",     N,               1'b0, 2'b00, 4'd0, 1'b0);
        step("uj0",      UJ,              1'b1, 2'b01, 4'd0, 1'b0);
        step("uj1",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // call: three cycles, remaining 2,1,0
        step("cal0",     CAL,             1'b1, 2'b10, 4'd2, 1'b0);
        step("cal1",     N,               1'b1, 2'b10, 4'd1, 1'b1);
        step("cal2",     N,               1'b1, 2'b10, 4'd0, 1'b1);
        step("cal3",     N,               1'b0, 2'b00, 4'd0, 1'b0);

        // call then interrupt in 2nd flush cycle: 5 cycles, cause 10 -> 11
        step("ci0",      CAL,             1'b1, 2'b10, 4'd2, 1'b0);
        step("ci1",      INT,             1'b1, 2'b10, 4'd1, 1'b1);
        step("ci2",      N,               1'b1, 2'b11, 4'd2, 1'b1);
        step("ci3",      N,               1'b1, 2'b11, 4'd1, 1'b1);
        step("ci4",      N,               1'b1, 2'b11, 4'd0, 1'b1);
        step("ci5",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // call with stall in flush cycles 2-3: 5 cycles
        step("cs0",      CAL,             1'b1, 2'b10, 4'd2, 1'b0);
        step("cs1",      STL,             1'b1, 2'b10, 4'd1, 1'b1);
        step("cs2",      STL,             1'b1, 2'b10, 4'd1, 1'b1);
        step("cs3",      N,               1'b1, 2'b10, 4'd1, 1'b1);
        step("cs4",      N,               1'b1, 2'b10, 4'd0, 1'b1);
        step("cs5",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // interrupt + jump together: interrupt wins, 4 cycles
        step("ij0",      INT | JMP,       1'b1, 2'b11, 4'd3, 1'b0);
        step("ij1",      N,               1'b1, 2'b11, 4'd2, 1'b1);
        step("ij2",      N,               1'b1, 2'b11, 4'd1, 1'b1);
        step("ij3",      N,               1'b1, 2'b11, 4'd0, 1'b1);
        step("ij4",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // reset in 2nd cycle of a call flush aborts it
        step("cr0",      CAL,             1'b1, 2'b10, 4'd2, 1'b0);
        step("cr1",      RST,             1'b0, 2'b00, 4'd0, 1'b0);
        step("cr2",      N,               1'b0, 2'b00, 4'd0, 1'b0);
        step("cr3",      JMP,             1'b1, 2'b01, 4'd0, 1'b0);
        step("cr4",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // call on final flush cycle: back-to-back with no gap
        step("bb0",      CAL,             1'b1, 2'b10, 4'd2, 1'b0);
        step("bb1",      N,               1'b1, 2'b10, 4'd1, 1'b1);
        step("bb2",      CAL,             1'b1, 2'b10, 4'd0, 1'b1);
        step("bb3",      N,               1'b1, 2'b10, 4'd1, 1'b1);
        step("bb4",      N,               1'b1, 2'b10, 4'd0, 1'b1);
        step("bb5",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // stall does not block acceptance in IDLE
        step("sj0",      STL | JMP,       1'b1, 2'b01, 4'd0, 1'b0);
        step("sj1",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // call held three cycles re-arms the count each cycle
        step("hc0",      CAL,             1'b1, 2'b10, 4'd2, 1'b0);
        step("hc1",      CAL,             1'b1, 2'b10, 4'd1, 1'b1);
        step("hc2",      CAL,             1'b1, 2'b10, 4'd1, 1'b1);
        step("hc3",      N,               1'b1, 2'b10, 4'd1, 1'b1);
        step("hc4",      N,               1'b1, 2'b10, 4'd0, 1'b1);
        step("hc5",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        // short jump during interrupt flush updates cause, not length
        step("ijf0",     INT,             1'b1, 2'b11, 4'd3, 1'b0);
        step("ijf1",     JMP,             1'b1, 2'b11, 4'd2, 1'b1);
        step("ijf2",     N,               1'b1, 2'b01, 4'd1, 1'b1);
        step("ijf3",     N,               1'b1, 2'b01, 4'd0, 1'b1);
        step("ijf4",     N,               1'b0, 2'b00, 4'd0, 1'b0);

        // call + jump together: call wins
        step("cj0",      CAL | UJ,        1'b1, 2'b10, 4'd2, 1'b0);
        step("cj1",      N,               1'b1, 2'b10, 4'd1, 1'b1);
        step("cj2",      N,               1'b1, 2'b10, 4'd0, 1'b1);
        step("cj3",      N,               1'b0, 2'b00, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
